// File: rtl/onedconv_ptrgen.sv
// onedconv_ptrgen
// Pointer and flag generator for the ONEDCONV control FSM. It consumes the
// FSM control strobes and keeps the tap index, the input read pointer, the
// window base address, the output column and the current row. It decodes the
// comparison flags that the FSM sequences on.
//
// Ports
//   ONEDCONV_PTRGEN_Clk          clock, all state on the rising edge
//   ONEDCONV_PTRGEN_Reset        asynchronous active-low reset
//   ONEDCONV_PTRGEN_Start        latch configuration, clear every counter, set Busy
//   ONEDCONV_PTRGEN_W_Rows       weight length K
//   ONEDCONV_PTRGEN_Conv_Stride  stride S
//   ONEDCONV_PTRGEN_Of_Colums    output columns per row N
//   ONEDCONV_PTRGEN_If_Rows      number of rows R
//   ONEDCONV_PTRGEN_Set_En       MAC step: advance tap index and read pointer
//   ONEDCONV_PTRGEN_O_En         window commit: move base by S, next column
//   ONEDCONV_PTRGEN_Wptclr       clear tap index
//   ONEDCONV_PTRGEN_Rptclr       end of row: clear column state, advance row
//   ONEDCONV_PTRGEN_Flag_Eqcw    tap index == K-1
//   ONEDCONV_PTRGEN_Flag_Eqst    column == N-1
//   ONEDCONV_PTRGEN_Flag_Eqcif   row == R-1
//   ONEDCONV_PTRGEN_W_Addr       tap index
//   ONEDCONV_PTRGEN_R_Addr       input column read address
//   ONEDCONV_PTRGEN_Current_Row  current row
//   ONEDCONV_PTRGEN_Busy         high from Start until the last row is cleared
//   ONEDCONV_PTRGEN_Done         one-cycle pulse after the last row is cleared
module onedconv_ptrgen #(
  parameter int BITWIDTH_OF_COLUMS = 11,
  parameter int BITWIDTH_IF_ROWS   = 10,
  parameter int BITWIDTH_W_ROWS    = 4,
  parameter int BITWIDTH_STRIDE    = 4,
  parameter int BITWIDTH_ADDR      = 12
) (
  input  logic                          ONEDCONV_PTRGEN_Clk,
  input  logic                          ONEDCONV_PTRGEN_Reset,
  input  logic                          ONEDCONV_PTRGEN_Start,
  input  logic [BITWIDTH_W_ROWS-1:0]    ONEDCONV_PTRGEN_W_Rows,
  input  logic [BITWIDTH_STRIDE-1:0]    ONEDCONV_PTRGEN_Conv_Stride,
  input  logic [BITWIDTH_OF_COLUMS-1:0] ONEDCONV_PTRGEN_Of_Colums,
  input  logic [BITWIDTH_IF_ROWS-1:0]   ONEDCONV_PTRGEN_If_Rows,
  input  logic                          ONEDCONV_PTRGEN_Set_En,
  input  logic                          ONEDCONV_PTRGEN_O_En,
  input  logic                          ONEDCONV_PTRGEN_Wptclr,
  input  logic                          ONEDCONV_PTRGEN_Rptclr,
  output logic                          ONEDCONV_PTRGEN_Flag_Eqcw,
  output logic                          ONEDCONV_PTRGEN_Flag_Eqst,
  output logic                          ONEDCONV_PTRGEN_Flag_Eqcif,
  output logic [BITWIDTH_W_ROWS-1:0]    ONEDCONV_PTRGEN_W_Addr,
  output logic [BITWIDTH_ADDR-1:0]      ONEDCONV_PTRGEN_R_Addr,
  output logic [BITWIDTH_IF_ROWS-1:0]   ONEDCONV_PTRGEN_Current_Row,
  output logic                          ONEDCONV_PTRGEN_Busy,
  output logic                          ONEDCONV_PTRGEN_Done
);

  // Latched configuration
  logic [BITWIDTH_W_ROWS-1:0]    cfg_k;
  logic [BITWIDTH_STRIDE-1:0]    cfg_s;
  logic [BITWIDTH_OF_COLUMS-1:0] cfg_n;
  logic [BITWIDTH_IF_ROWS-1:0]   cfg_r;

  // Working counters
  logic [BITWIDTH_W_ROWS-1:0]    wpt;
  logic [BITWIDTH_ADDR-1:0]      rpt;
  logic [BITWIDTH_ADDR-1:0]      base;
  logic [BITWIDTH_OF_COLUMS-1:0] col;
  logic [BITWIDTH_IF_ROWS-1:0]   row;
  logic                          busy;
  logic                          done;

  // Compare targets. With a zero configuration these wrap to all-ones.
  logic [BITWIDTH_W_ROWS-1:0]    last_tap;
  logic [BITWIDTH_OF_COLUMS-1:0] last_col;
  logic [BITWIDTH_IF_ROWS-1:0]   last_row;
  logic [BITWIDTH_ADDR-1:0]      next_base;
  logic                          at_last_row;

  assign last_tap    = cfg_k - BITWIDTH_W_ROWS'(1);
  assign last_col    = cfg_n - BITWIDTH_OF_COLUMS'(1);
  assign last_row    = cfg_r - BITWIDTH_IF_ROWS'(1);
  assign next_base   = base + BITWIDTH_ADDR'(cfg_s);
  assign at_last_row = (row == last_row);

  // Start has priority over every strobe.
  // Row-state priority is Rptclr, then O_En, then Set_En.
  // Done is only raised while a run is active.
  always_ff @(posedge ONEDCONV_PTRGEN_Clk or negedge ONEDCONV_PTRGEN_Reset) begin
    if (!ONEDCONV_PTRGEN_Reset) begin
      cfg_k <= '0;
      cfg_s <= '0;
      cfg_n <= '0;
      cfg_r <= '0;
      wpt   <= '0;
      rpt   <= '0;
      base  <= '0;
      col   <= '0;
      row   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else if (ONEDCONV_PTRGEN_Start) begin
      cfg_k <= ONEDCONV_PTRGEN_W_Rows;
      cfg_s <= ONEDCONV_PTRGEN_Conv_Stride;
      cfg_n <= ONEDCONV_PTRGEN_Of_Colums;
      cfg_r <= ONEDCONV_PTRGEN_If_Rows;
      wpt   <= '0;
      rpt   <= '0;
      base  <= '0;
      col   <= '0;
      row   <= '0;
      busy  <= 1'b1;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;

      if (ONEDCONV_PTRGEN_Wptclr) begin
        wpt <= '0;
      end else if (ONEDCONV_PTRGEN_Set_En) begin
        wpt <= wpt + BITWIDTH_W_ROWS'(1);
      end

      if (ONEDCONV_PTRGEN_Rptclr) begin
        base <= '0;
        rpt  <= '0;
        col  <= '0;
        if (at_last_row) begin
          row <= '0;
          if (busy) begin
            done <= 1'b1;
            busy <= 1'b0;
          end
        end else begin
          row <= row + BITWIDTH_IF_ROWS'(1);
        end
      end else if (ONEDCONV_PTRGEN_O_En) begin
        // The new window starts at the new base; any concurrent Set_En step is dropped.
        base <= next_base;
        rpt  <= next_base;
        col  <= col + BITWIDTH_OF_COLUMS'(1);
      end else if (ONEDCONV_PTRGEN_Set_En) begin
        rpt <= rpt + BITWIDTH_ADDR'(1);
      end
    end
  end

  // Flags are suppressed for a zero configuration so that an illegal K, N or R
  // can never produce a match, even after a counter wraps to all-ones.
  assign ONEDCONV_PTRGEN_Flag_Eqcw   = (cfg_k != '0) && (wpt == last_tap);
  assign ONEDCONV_PTRGEN_Flag_Eqst   = (cfg_n != '0) && (col == last_col);
  assign ONEDCONV_PTRGEN_Flag_Eqcif  = (cfg_r != '0) && at_last_row;
  assign ONEDCONV_PTRGEN_W_Addr      = wpt;
  assign ONEDCONV_PTRGEN_R_Addr      = rpt;
  assign ONEDCONV_PTRGEN_Current_Row = row;
  assign ONEDCONV_PTRGEN_Busy        = busy;
  assign ONEDCONV_PTRGEN_Done        = done;

endmodule

// File: tb/tb_onedconv_ptrgen.sv
// tb_onedconv_ptrgen
// Self-checking bench for onedconv_ptrgen. The driver issues one strobe set per
// cycle and steps a behavioural model. It then pushes the predicted outputs
// into a queue. A monitor pops one entry after each rising edge and compares it
// with the DUT. Directed sequences follow the usage scenarios. A long random
// run follows them.
module tb_onedconv_ptrgen;

  logic        tb_clk = 1'b0;
  logic        rst_n;
  logic        start, set_en, o_en, wptclr, rptclr;
  logic [3:0]  w_rows, conv_stride;
  logic [10:0] of_colums;
  logic [9:0]  if_rows;

  logic        flag_eqcw, flag_eqst, flag_eqcif, busy, done;
  logic [3:0]  w_addr;
  logic [11:0] r_addr;
  logic [9:0]  current_row;

  int tests = 0;
  int fails = 0;

  always #5 tb_clk = ~tb_clk;

  onedconv_ptrgen dut (
    .ONEDCONV_PTRGEN_Clk         (tb_clk),
    .ONEDCONV_PTRGEN_Reset       (rst_n),
    .ONEDCONV_PTRGEN_Start       (start),
    .ONEDCONV_PTRGEN_W_Rows      (w_rows),
    .ONEDCONV_PTRGEN_Conv_Stride (conv_stride),
    .ONEDCONV_PTRGEN_Of_Colums   (of_colums),
    .ONEDCONV_PTRGEN_If_Rows     (if_rows),
    .ONEDCONV_PTRGEN_Set_En      (set_en),
    .ONEDCONV_PTRGEN_O_En        (o_en),
    .ONEDCONV_PTRGEN_Wptclr      (wptclr),
    .ONEDCONV_PTRGEN_Rptclr      (rptclr),
    .ONEDCONV_PTRGEN_Flag_Eqcw   (flag_eqcw),
    .ONEDCONV_PTRGEN_Flag_Eqst   (flag_eqst),
    .ONEDCONV_PTRGEN_Flag_Eqcif  (flag_eqcif),
    .ONEDCONV_PTRGEN_W_Addr      (w_addr),
    .ONEDCONV_PTRGEN_R_Addr      (r_addr),
    .ONEDCONV_PTRGEN_Current_Row (current_row),
    .ONEDCONV_PTRGEN_Busy        (busy),
    .ONEDCONV_PTRGEN_Done        (done)
  );

  // Behavioural state: plain integers, with modular wrap applied explicitly
  typedef struct {
    int k, s, n, r;
    int wpt, rpt, base, col, row;
    bit busy, done;
  } model_t;

  typedef struct {
    bit eqcw, eqst, eqcif, busy, done;
    int w_addr, r_addr, cur_row;
  } exp_t;

  model_t m;
  exp_t   sb_q[$];

  function automatic model_t model_reset();
    model_t x;
    x = '{k:0, s:0, n:0, r:0, wpt:0, rpt:0, base:0, col:0, row:0, busy:0, done:0};
    return x;
  endfunction

  // One clock edge of the pointer generator, described in terms of windows and rows
  function automatic model_t model_step(model_t cur, bit st, bit se, bit oe, bit wc, bit rc,
                                        int k, int s, int n, int r);
    model_t x = cur;
    x.done = 0;
    if (st) begin
      x = model_reset();
      x.k = k; x.s = s; x.n = n; x.r = r;
      x.busy = 1;
      return x;
    end
    if (wc)      x.wpt = 0;
    else if (se) x.wpt = (cur.wpt + 1) % 16;
    if (rc) begin
      x.base = 0; x.rpt = 0; x.col = 0;
      if (cur.row == (cur.r + 1023) % 1024) begin
        x.row = 0;
        if (cur.busy) begin
          x.done = 1;
          x.busy = 0;
        end
      end else begin
        x.row = (cur.row + 1) % 1024;
      end
    end else if (oe) begin
      x.base = (cur.base + cur.s) % 4096;
      x.rpt  = x.base;
      x.col  = (cur.col + 1) % 2048;
    end else if (se) begin
      x.rpt = (cur.rpt + 1) % 4096;
    end
    return x;
  endfunction

  function automatic exp_t predict(model_t x);
    exp_t e;
    e.eqcw    = (x.k != 0) && (x.wpt == x.k - 1);
    e.eqst    = (x.n != 0) && (x.col == x.n - 1);
    e.eqcif   = (x.r != 0) && (x.row == x.r - 1);
    e.w_addr  = x.wpt;
    e.r_addr  = x.rpt;
    e.cur_row = x.row;
    e.busy    = x.busy;
    e.done    = x.done;
    return e;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of strobes at the falling edge, then record the prediction
  task automatic applyStimulus(input bit st, input bit se, input bit oe, input bit wc, input bit rc);
    @(negedge tb_clk);
    start = st; set_en = se; o_en = oe; wptclr = wc; rptclr = rc;
    m = model_step(m, st, se, oe, wc, rc, int'(w_rows), int'(conv_stride),
                   int'(of_colums), int'(if_rows));
    sb_q.push_back(predict(m));
  endtask

  task automatic settle();
    @(posedge tb_clk);
    #2;
  endtask

  task automatic setConfig(input int k, input int s, input int n, input int r);
    w_rows = 4'(k); conv_stride = 4'(s); of_colums = 11'(n); if_rows = 10'(r);
  endtask

  // Monitor: every rising edge presents a new output set to compare
  initial begin
    exp_t e;
    forever begin
      @(posedge tb_clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checkOutput("Flag_Eqcw",   flag_eqcw,   e.eqcw);
        checkOutput("Flag_Eqst",   flag_eqst,   e.eqst);
        checkOutput("Flag_Eqcif",  flag_eqcif,  e.eqcif);
        checkOutput("W_Addr",      w_addr,      e.w_addr);
        checkOutput("R_Addr",      r_addr,      e.r_addr);
        checkOutput("Current_Row", current_row, e.cur_row);
        checkOutput("Busy",        busy,        e.busy);
        checkOutput("Done",        done,        e.done);
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst_n = 1'b0;
    start = 0; set_en = 0; o_en = 0; wptclr = 0; rptclr = 0;
    setConfig(0, 0, 0, 0);
    m = model_reset();
    #12;
    checkOutput("reset Flag_Eqcw",   flag_eqcw,   0);
    checkOutput("reset Flag_Eqst",   flag_eqst,   0);
    checkOutput("reset Flag_Eqcif",  flag_eqcif,  0);
    checkOutput("reset R_Addr",      r_addr,      0);
    checkOutput("reset W_Addr",      w_addr,      0);
    checkOutput("reset Current_Row", current_row, 0);
    checkOutput("reset Busy",        busy,        0);
    checkOutput("reset Done",        done,        0);
    @(negedge tb_clk);
    rst_n = 1'b1;

    // Idle with zero configuration: the read pointer counts and the flags stay low
    repeat (3) applyStimulus(0, 1, 0, 0, 0);
    settle();
    checkOutput("idle R_Addr", r_addr, 3);
    checkOutput("idle Flag_Eqcw", flag_eqcw, 0);

    // K=2 S=1 N=5 R=6: first taps, then a window commit
    setConfig(2, 1, 5, 6);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    settle();
    checkOutput("first tap W_Addr", w_addr, 1);
    checkOutput("first tap Flag_Eqcw", flag_eqcw, 1);
    applyStimulus(0, 1, 0, 0, 0);
    settle();
    checkOutput("second tap R_Addr", r_addr, 2);
    applyStimulus(0, 0, 1, 1, 0);
    settle();
    checkOutput("commit W_Addr", w_addr, 0);
    checkOutput("commit R_Addr", r_addr, 1);
    for (int w = 2; w <= 4; w++) begin
      applyStimulus(0, 1, 0, 0, 0);
      applyStimulus(0, 1, 0, 0, 0);
      applyStimulus(0, 0, 1, 1, 0);
      settle();
      checkOutput("window start R_Addr", r_addr, w);
    end
    checkOutput("last column Flag_Eqst", flag_eqst, 1);
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 1);
    settle();
    checkOutput("row end R_Addr", r_addr, 0);
    checkOutput("row end Current_Row", current_row, 1);

    // Stride 3, three taps, three windows
    setConfig(3, 3, 3, 2);
    applyStimulus(1, 0, 0, 0, 0);
    for (int w = 0; w < 3; w++) begin
      settle();
      checkOutput("stride window base", r_addr, 3 * w);
      applyStimulus(0, 1, 0, 0, 0);
      applyStimulus(0, 1, 0, 0, 0);
      if (w == 2) begin
        settle();
        checkOutput("stride last tap R_Addr", r_addr, 8);
        checkOutput("stride last tap Flag_Eqcw", flag_eqcw, 1);
      end
      applyStimulus(0, 0, 1, 1, 0);
    end

    // Six complete rows, ending in Done
    setConfig(2, 1, 5, 6);
    applyStimulus(1, 0, 0, 0, 0);
    for (int r = 0; r < 6; r++) begin
      settle();
      checkOutput("rows Current_Row", current_row, r);
      checkOutput("rows Flag_Eqcif", flag_eqcif, (r == 5) ? 1 : 0);
      applyStimulus(0, 1, 0, 0, 0);
      applyStimulus(0, 0, 1, 1, 0);
      applyStimulus(0, 0, 0, 0, 1);
    end
    settle();
    checkOutput("final Done", done, 1);
    checkOutput("final Busy", busy, 0);
    checkOutput("final Current_Row", current_row, 0);
    applyStimulus(0, 0, 0, 0, 0);
    settle();
    checkOutput("Done pulse width", done, 0);

    // Set_En with O_En: the read pointer lands on the new base
    setConfig(4, 2, 4, 3);
    applyStimulus(1, 0, 0, 0, 0);
    repeat (3) applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0);
    settle();
    checkOutput("Set_En+O_En R_Addr", r_addr, 2);

    // Start with Rptclr on a single-row run: Start wins and no Done
    setConfig(2, 1, 5, 1);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 1);
    settle();
    checkOutput("Start+Rptclr Done", done, 0);
    checkOutput("Start+Rptclr Busy", busy, 1);
    checkOutput("Start+Rptclr R_Addr", r_addr, 0);

    // Asynchronous reset in the middle of a row
    setConfig(3, 2, 4, 4);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    settle();
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset R_Addr", r_addr, 0);
    checkOutput("async reset W_Addr", w_addr, 0);
    checkOutput("async reset Busy", busy, 0);
    checkOutput("async reset Flag_Eqcw", flag_eqcw, 0);
    m = model_reset();
    @(negedge tb_clk);
    rst_n = 1'b1;

    // Random run against the model
    begin
      bit st, se, oe, wc, rc;
      for (int i = 0; i < 1500; i++) begin
        st = (i == 0) || ($urandom_range(99) < 2);
        if (st)
          setConfig($urandom_range(15, 1), $urandom_range(7, 0),
                    $urandom_range(6, 1), $urandom_range(4, 1));
        se = ($urandom_range(99) < 50);
        oe = ($urandom_range(99) < 20);
        wc = ($urandom_range(99) < 25);
        rc = ($urandom_range(99) < 8);
        applyStimulus(st, se, oe, wc, rc);
      end
    end
    applyStimulus(0, 0, 0, 0, 0);
    settle();
    settle();
    checkOutput("scoreboard drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
